// File: rtl/vote_pkg.sv
// Shared encodings and helpers for the weighted vote session controller.
// Classes: NP (weight 1, ids 0..31), VIP (weight 4, ids 0..7), VVIP (weight 16, id 0).
package vote_pkg;
    localparam int TALLY_W = 7;
    localparam int BOOK_W  = 41;

    typedef enum logic [1:0] {
        CLS_NP   = 2'd0,
        CLS_VIP  = 2'd1,
        CLS_VVIP = 2'd2,
        CLS_BAD  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [TALLY_W-1:0] W_NP   = 7'd1;
    localparam logic [TALLY_W-1:0] W_VIP  = 7'd4;
    localparam logic [TALLY_W-1:0] W_VVIP = 7'd16;

    // Class is legal and id lies inside that class's voter range.
    function automatic logic ballot_legal(cls_e c, logic [4:0] id);
        case (c)
            CLS_NP:   return 1'b1;
            CLS_VIP:  return (id[4:3] == 2'b00);
            CLS_VVIP: return (id == 5'd0);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [TALLY_W-1:0] ballot_weight(cls_e c);
        case (c)
            CLS_NP:   return W_NP;
            CLS_VIP:  return W_VIP;
            CLS_VVIP: return W_VVIP;
            default:  return '0;
        endcase
    endfunction
endpackage

// File: rtl/vote_session_ctrl_if.sv
// Ballot port: serial valid/ready handshake plus the one-cycle accept/reject pulses.
//   master: ballot source (drives valid/class/id, sees ready/ok/rej)
//   slave : vote_session_ctrl
interface vote_session_ctrl_if;
    logic       ballot_valid;
    logic       ballot_ready;
    logic [1:0] ballot_class;
    logic [4:0] ballot_id;
    logic       ballot_ok;
    logic       ballot_rej;

    modport master (
        output ballot_valid, ballot_class, ballot_id,
        input  ballot_ready, ballot_ok, ballot_rej
    );

    modport slave (
        input  ballot_valid, ballot_class, ballot_id,
        output ballot_ready, ballot_ok, ballot_rej
    );
endinterface

// File: rtl/vote_ballot_book.sv
// Voter book: 41-bit test-and-set register recording who has already voted.
//   Layout: NP ids at [31:0], VIP ids at [39:32], VVIP at [40].
//   i_class/i_id : voter being looked up
//   o_test       : combinational hit (voter already recorded)
//   i_set        : record the voter on this edge
//   i_clear      : synchronous clear of the whole book (new session)
module vote_ballot_book
    import vote_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  cls_e       i_class,
    input  logic [4:0] i_id,
    output logic       o_test,
    input  logic       i_set,
    input  logic       i_clear
);
    logic [BOOK_W-1:0] r_book;
    logic [5:0]        w_idx;

    // Illegal classes map to bit 0; the caller never sets a bit for them,
    // so the resulting hit value is irrelevant.
    always_comb begin
        w_idx = 6'd0;
        case (i_class)
            CLS_NP:   w_idx = {1'b0, i_id};
            CLS_VIP:  w_idx = 6'd32 + {3'b000, i_id[2:0]};
            CLS_VVIP: w_idx = 6'd40;
            default:  w_idx = 6'd0;
        endcase
    end

    assign o_test = r_book[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_book <= '0;
        end else if (i_clear) begin
            r_book <= '0;
        end else if (i_set) begin
            r_book[w_idx] <= 1'b1;
        end
    end
endmodule

// File: rtl/vote_session_ctrl.sv
// Weighted vote session controller: opens a ballot window, takes one ballot per
// cycle, rejects duplicates/illegal ballots, accumulates the weighted tally and
// closes on command, timeout or early pass, then holds the pass/fail result.
//   clk, rst_n : clock, async active-low reset
//   start      : open a session from IDLE or DONE
//   close      : end the session from OPEN
//   bif        : ballot handshake (valid/ready/class/id, ok/rej pulses)
//   busy, done : state == OPEN / state == DONE
//   res        : tally >= THRESH, captured on entry to DONE
//   tally      : running weighted total
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT    = 256,
    parameter int THRESH     = 32,
    parameter int EARLY_PASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               close,
    vote_session_ctrl_if.slave bif,
    output logic               busy,
    output logic               done,
    output logic               res,
    output logic [TALLY_W-1:0] tally
);
    localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TALLY_W-1:0] THR = TALLY_W'(THRESH);

    state_e             r_state;
    logic [TALLY_W-1:0] r_tally;
    logic [TMR_W-1:0]   r_timer;
    logic               r_res;
    logic               r_ok;
    logic               r_rej;

    cls_e               w_cls;
    logic               w_open;
    logic               w_xfer;
    logic               w_hit;
    logic               w_acc;
    logic [TALLY_W-1:0] w_tally_nx;
    logic               w_tmo;
    logic               w_early;
    logic               w_clear;

    assign w_cls   = cls_e'(bif.ballot_class);
    assign w_open  = (r_state == S_OPEN);
    assign w_xfer  = bif.ballot_valid & w_open;
    assign w_acc   = w_xfer & ballot_legal(w_cls, bif.ballot_id) & ~w_hit;
    // Max reachable total is 80, so the 7-bit sum never wraps.
    assign w_tally_nx = w_acc ? r_tally + ballot_weight(w_cls) : r_tally;
    assign w_tmo   = (TIMEOUT != 0) && (r_timer == TMR_W'(TMO_LAST));
    assign w_early = (EARLY_PASS != 0) && (w_tally_nx >= THR);
    assign w_clear = start & ~w_open;

    vote_ballot_book u_book (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_class (w_cls),
        .i_id    (bif.ballot_id),
        .o_test  (w_hit),
        .i_set   (w_acc),
        .i_clear (w_clear)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tally <= '0;
            r_timer <= '0;
            r_res   <= 1'b0;
            r_ok    <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_ok  <= w_acc;
            r_rej <= w_xfer & ~w_acc;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_OPEN;
                        r_tally <= '0;
                        r_timer <= '0;
                        r_res   <= 1'b0;
                    end
                end
                S_OPEN: begin
                    // start is ignored here; a ballot arriving alongside the
                    // closing condition is still counted into the result.
                    r_tally <= w_tally_nx;
                    r_timer <= r_timer + 1'b1;
                    if (close | w_tmo | w_early) begin
                        r_state <= S_DONE;
                        r_res   <= (w_tally_nx >= THR);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bif.ballot_ready = w_open;
    assign bif.ballot_ok    = r_ok;
    assign bif.ballot_rej   = r_rej;
    assign busy  = w_open;
    assign done  = (r_state == S_DONE);
    assign res   = r_res;
    assign tally = r_tally;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: three instances (no early pass / early pass /
// short timeout) share one stimulus bus gated by sel; accept/reject pulses are
// checked against a scoreboard of expected outcomes.
module tb_vote_session_ctrl;
    import vote_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sel = 2'd0;
    logic       t_start = 1'b0, t_close = 1'b0, t_valid = 1'b0;
    logic [1:0] t_cls = 2'd0;
    logic [4:0] t_id = 5'd0;

    vote_session_ctrl_if ifa ();
    vote_session_ctrl_if ifb ();
    vote_session_ctrl_if ifc ();

    assign ifa.ballot_valid = t_valid & (sel == 2'd0);
    assign ifb.ballot_valid = t_valid & (sel == 2'd1);
    assign ifc.ballot_valid = t_valid & (sel == 2'd2);
    assign ifa.ballot_class = t_cls;
    assign ifb.ballot_class = t_cls;
    assign ifc.ballot_class = t_cls;
    assign ifa.ballot_id    = t_id;
    assign ifb.ballot_id    = t_id;
    assign ifc.ballot_id    = t_id;

    logic busy_a, done_a, res_a, busy_b, done_b, res_b, busy_c, done_c, res_c;
    logic [6:0] tally_a, tally_b, tally_c;

    vote_session_ctrl #(.TIMEOUT(256), .THRESH(32), .EARLY_PASS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(t_start & (sel == 2'd0)),
        .close(t_close & (sel == 2'd0)), .bif(ifa),
        .busy(busy_a), .done(done_a), .res(res_a), .tally(tally_a));
    vote_session_ctrl #(.TIMEOUT(256), .THRESH(32), .EARLY_PASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(t_start & (sel == 2'd1)),
        .close(t_close & (sel == 2'd1)), .bif(ifb),
        .busy(busy_b), .done(done_b), .res(res_b), .tally(tally_b));
    vote_session_ctrl #(.TIMEOUT(8), .THRESH(32), .EARLY_PASS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(t_start & (sel == 2'd2)),
        .close(t_close & (sel == 2'd2)), .bif(ifc),
        .busy(busy_c), .done(done_c), .res(res_c), .tally(tally_c));

    logic m_ready, m_ok, m_rej, m_busy, m_done, m_res;
    logic [6:0] m_tally;
    always_comb begin
        case (sel)
            2'd1: {m_ready, m_ok, m_rej, m_busy, m_done, m_res, m_tally} =
                  {ifb.ballot_ready, ifb.ballot_ok, ifb.ballot_rej, busy_b, done_b, res_b, tally_b};
            2'd2: {m_ready, m_ok, m_rej, m_busy, m_done, m_res, m_tally} =
                  {ifc.ballot_ready, ifc.ballot_ok, ifc.ballot_rej, busy_c, done_c, res_c, tally_c};
            default: {m_ready, m_ok, m_rej, m_busy, m_done, m_res, m_tally} =
                  {ifa.ballot_ready, ifa.ballot_ok, ifa.ballot_rej, busy_a, done_a, res_a, tally_a};
        endcase
    end

    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_q[$];
    logic e_ok;

    // Scoreboard: every ok/rej pulse must match the oldest expected outcome.
    always @(negedge clk) begin
        if (rst_n && (m_ok || m_rej)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL pulse_unexpected ok=%0b rej=%0b, required none", m_ok, m_rej);
            end else begin
                e_ok = exp_q.pop_front();
                if ({m_ok, m_rej} !== {e_ok, ~e_ok})
                    $display("FAIL pulse_kind ok=%0b rej=%0b, required ok=%0b rej=%0b",
                             m_ok, m_rej, e_ok, ~e_ok);
                else n_pass++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        t_start = 1'b1; cyc(1); t_start = 1'b0;
    endtask

    task automatic pulse_close();
        t_close = 1'b1; cyc(1); t_close = 1'b0;
    endtask

    // code: 0 = expect reject, 1 = expect accept, 2 = expect drop (not ready)
    task automatic ballot(input logic [1:0] c, input logic [4:0] id, input int code);
        t_cls = c; t_id = id; t_valid = 1'b1;
        if (code == 2) begin
            #1;
            n_chk++;
            if (m_ready !== 1'b0) $display("FAIL drop_ready ready=%0b, required 0", m_ready);
            else n_pass++;
        end else begin
            exp_q.push_back(code == 1);
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s[1:0]; #1;
            n_chk++;
            if ({m_ready, m_ok, m_rej, m_busy, m_done, m_res, m_tally} !== 13'd0)
                $display("FAIL reset_outs dut%0d got=%b, required all zero", s,
                         {m_ready, m_ok, m_rej, m_busy, m_done, m_res, m_tally});
            else n_pass++;
        end
        sel = 2'd0;
    endtask

    task automatic test_np_close();
        sel = 2'd0;
        pulse_start();
        for (int i = 0; i < 32; i++) ballot(2'd0, 5'(i), 1);
        cyc(1);
        n_chk++;
        if ({m_busy, m_done, m_tally} !== {1'b1, 1'b0, 7'd32})
            $display("FAIL np_open busy=%0b done=%0b tally=%0d, required 1 0 32", m_busy, m_done, m_tally);
        else n_pass++;
        pulse_close();
        n_chk++;
        if ({m_busy, m_done, m_res, m_tally} !== {1'b0, 1'b1, 1'b1, 7'd32})
            $display("FAIL np_close busy=%0b done=%0b res=%0b tally=%0d, required 0 1 1 32",
                     m_busy, m_done, m_res, m_tally);
        else n_pass++;
    endtask

    task automatic test_vip_np();
        sel = 2'd0;
        pulse_start();
        n_chk++;
        if ({m_done, m_res, m_tally} !== {1'b0, 1'b0, 7'd0})
            $display("FAIL restart_clear done=%0b res=%0b tally=%0d, required 0 0 0", m_done, m_res, m_tally);
        else n_pass++;
        for (int i = 0; i < 7; i++) ballot(2'd1, 5'(i), 1);
        for (int i = 0; i < 3; i++) ballot(2'd0, 5'(i), 1);
        cyc(1);
        pulse_close();
        n_chk++;
        if ({m_done, m_res, m_tally} !== {1'b1, 1'b0, 7'd31})
            $display("FAIL vip_np done=%0b res=%0b tally=%0d, required 1 0 31", m_done, m_res, m_tally);
        else n_pass++;
        ballot(2'd2, 5'd0, 2);
        cyc(2);
        n_chk++;
        if (m_tally !== 7'd31) $display("FAIL drop_in_done tally=%0d, required 31", m_tally);
        else n_pass++;
    endtask

    task automatic test_reject();
        sel = 2'd0;
        pulse_start();
        ballot(2'd1, 5'd2, 1);
        ballot(2'd1, 5'd2, 0);
        ballot(2'd2, 5'd1, 0);
        ballot(2'd3, 5'd0, 0);
        ballot(2'd1, 5'd8, 0);
        cyc(1);
        n_chk++;
        if (m_tally !== 7'd4) $display("FAIL reject_tally tally=%0d, required 4", m_tally);
        else n_pass++;
        // Ballot coincident with close is still counted.
        t_close = 1'b1;
        ballot(2'd0, 5'd31, 1);
        t_close = 1'b0;
        n_chk++;
        if ({m_done, m_tally} !== {1'b1, 7'd5})
            $display("FAIL close_with_ballot done=%0b tally=%0d, required 1 5", m_done, m_tally);
        else n_pass++;
        cyc(1);
    endtask

    task automatic test_early_pass();
        sel = 2'd1;
        pulse_start();
        ballot(2'd2, 5'd0, 1);
        for (int i = 0; i < 3; i++) ballot(2'd1, 5'(i), 1);
        n_chk++;
        if ({m_busy, m_tally} !== {1'b1, 7'd28})
            $display("FAIL early_pre busy=%0b tally=%0d, required 1 28", m_busy, m_tally);
        else n_pass++;
        ballot(2'd1, 5'd3, 1);
        n_chk++;
        if ({m_busy, m_done, m_res, m_tally} !== {1'b0, 1'b1, 1'b1, 7'd32})
            $display("FAIL early_pass busy=%0b done=%0b res=%0b tally=%0d, required 0 1 1 32",
                     m_busy, m_done, m_res, m_tally);
        else n_pass++;
        ballot(2'd0, 5'd0, 2);
        cyc(2);
        n_chk++;
        if (m_tally !== 7'd32) $display("FAIL early_drop tally=%0d, required 32", m_tally);
        else n_pass++;
    endtask

    task automatic test_timeout();
        sel = 2'd2;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if ({m_busy, m_done} !== 2'b10)
                $display("FAIL tmo_open cycle=%0d busy=%0b done=%0b, required 1 0", k, m_busy, m_done);
            else n_pass++;
            cyc(1);
        end
        n_chk++;
        if ({m_busy, m_done, m_res} !== 3'b010)
            $display("FAIL tmo_done busy=%0b done=%0b res=%0b, required 0 1 0", m_busy, m_done, m_res);
        else n_pass++;
        pulse_start();
        cyc(7);
        ballot(2'd0, 5'd3, 1);
        n_chk++;
        if ({m_done, m_res, m_tally} !== {1'b1, 1'b0, 7'd1})
            $display("FAIL tmo_last_ballot done=%0b res=%0b tally=%0d, required 1 0 1", m_done, m_res, m_tally);
        else n_pass++;
        cyc(1);
    endtask

    task automatic test_reset_mid();
        sel = 2'd0;
        pulse_start();
        for (int i = 0; i < 3; i++) ballot(2'd1, 5'(i), 1);
        cyc(1);
        n_chk++;
        if (m_tally !== 7'd12) $display("FAIL mid_tally tally=%0d, required 12", m_tally);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({m_busy, m_done, m_tally} !== {1'b0, 1'b0, 7'd0})
            $display("FAIL async_reset busy=%0b done=%0b tally=%0d, required 0 0 0", m_busy, m_done, m_tally);
        else n_pass++;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pulse_start();
        ballot(2'd1, 5'd0, 1);
        cyc(1);
        n_chk++;
        if (m_tally !== 7'd4) $display("FAIL clean_book tally=%0d, required 4", m_tally);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        #3;
        test_reset();
        #4 rst_n = 1'b1;
        cyc(1);
        test_np_close();
        test_vip_np();
        test_reject();
        test_early_pass();
        test_timeout();
        test_reset_mid();
        cyc(2);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL missing_pulses pending=%0d, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
